// File: rtl/abs_diff_pipe_if.sv
// abs_diff_pipe_if: sample-in / magnitude-out handshake bundle for the gradient abs-diff unit
interface abs_diff_pipe_if #(
  parameter int pixelBitWidth = 14,
  parameter int sumBitWidth   = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic [pixelBitWidth-1:0] green_h;
  logic [pixelBitWidth-1:0] green_v;
  logic                     out_valid;
  logic                     out_ready;
  logic [pixelBitWidth-2:0] absolute_diff;
  logic                     h_less;
  logic                     win_last;
  logic [sumBitWidth-1:0]   window_sum;
  logic                     win_v_major;
  modport master (
    output in_valid, green_h, green_v, out_ready,
    input  in_ready, out_valid, absolute_diff, h_less, win_last, window_sum, win_v_major
  );
  modport slave (
    input  in_valid, green_h, green_v, out_ready,
    output in_ready, out_valid, absolute_diff, h_less, win_last, window_sum, win_v_major
  );
endinterface

// File: rtl/abs_diff_pipe.sv
// abs_diff_pipe: 2-stage saturated |green_h-green_v| with windowed sum and direction vote
module abs_diff_pipe #(
  parameter int pixelBitWidth = 14,
  parameter int windowLength  = 5,
  parameter int sumBitWidth   = 16
) (
  input logic            clk,
  input logic            rst_n,
  input logic            clear_i,
  abs_diff_pipe_if.slave bus
);
  localparam int PW = pixelBitWidth;
  logic                   en;
  logic                   s1_valid_q;
  logic [PW:0]            diff_q;
  logic [PW:0]            mag;
  logic [PW-2:0]          abs_d, abs_q;
  logic                   out_valid_q, h_less_q, win_last_q, win_v_major_q;
  logic [sumBitWidth-1:0] sum_q, sum_d, window_sum_q;
  logic [7:0]             cnt_q, hcnt_q, hcnt_d;
  logic                   last;
  always_comb begin
    en     = !out_valid_q || bus.out_ready;
    mag    = diff_q[PW] ? -diff_q : diff_q;
    abs_d  = |mag[PW:PW-1] ? '1 : mag[PW-2:0];
    last   = cnt_q == 8'(windowLength - 1);
    sum_d  = sum_q + sumBitWidth'(abs_d);
    hcnt_d = hcnt_q + 8'(diff_q[PW]);
  end
  assign bus.in_ready      = en || clear_i;
  assign bus.out_valid     = out_valid_q;
  assign bus.absolute_diff = abs_q;
  assign bus.h_less        = h_less_q;
  assign bus.win_last      = win_last_q;
  assign bus.window_sum    = window_sum_q;
  assign bus.win_v_major   = win_v_major_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      diff_q        <= '0;
      out_valid_q   <= 1'b0;
      abs_q         <= '0;
      h_less_q      <= 1'b0;
      win_last_q    <= 1'b0;
      window_sum_q  <= '0;
      win_v_major_q <= 1'b0;
      cnt_q         <= '0;
      sum_q         <= '0;
      hcnt_q        <= '0;
    end else if (clear_i) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
      cnt_q       <= '0;
      sum_q       <= '0;
      hcnt_q      <= '0;
    end else if (en) begin
      s1_valid_q  <= bus.in_valid;
      out_valid_q <= s1_valid_q;
      win_last_q  <= s1_valid_q && last;
      if (bus.in_valid) diff_q <= {1'b0, bus.green_h} - {1'b0, bus.green_v};
      // window state only moves with real samples, so bubbles never shift the boundary
      if (s1_valid_q) begin
        abs_q    <= abs_d;
        h_less_q <= diff_q[PW];
        cnt_q    <= last ? '0 : cnt_q + 8'd1;
        sum_q    <= last ? '0 : sum_d;
        hcnt_q   <= last ? '0 : hcnt_d;
        if (last) begin
          window_sum_q  <= sum_d;
          win_v_major_q <= hcnt_d > 8'(windowLength / 2);
        end
      end
    end
  end
endmodule

// File: tb/tb_abs_diff_pipe.sv
// tb_abs_diff_pipe: random + directed stimulus against a queue-based reference model
module tb_abs_diff_pipe;
  logic clk, rst_n, clear;
  abs_diff_pipe_if #(.pixelBitWidth(14), .sumBitWidth(16)) bus ();
  abs_diff_pipe #(.pixelBitWidth(14), .windowLength(5), .sumBitWidth(16)) dut (
    .clk(clk), .rst_n(rst_n), .clear_i(clear), .bus(bus)
  );
  typedef struct {
    int abs_v; int hl; int last; int sum; int vmaj; int cyc;
  } exp_t;
  exp_t q[$];
  int seen_abs[$], seen_hl[$], seen_last[$], seen_sum[$], seen_vmaj[$];
  int errors = 0, checks = 0, cyc = 0, lat = 0;
  int wcnt = 0, wsum = 0, whl = 0;
  logic prev_stall = 0, prev_clr = 0;
  logic [31:0] snap_abs, snap_last, snap_sum;
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    q.delete();
    wcnt = 0; wsum = 0; whl = 0;
    prev_stall = 0; prev_clr = 0;
  endtask
  task automatic push(input int h, input int v);
    exp_t e;
    int d;
    d = h > v ? h - v : v - h;
    e.abs_v = d > 8191 ? 8191 : d;
    e.hl = h < v ? 1 : 0;
    wcnt++; wsum += e.abs_v; whl += e.hl;
    e.last = wcnt == 5 ? 1 : 0;
    e.sum = wsum;
    e.vmaj = whl > 2 ? 1 : 0;
    e.cyc = cyc;
    if (e.last == 1) begin wcnt = 0; wsum = 0; whl = 0; end
    q.push_back(e);
  endtask
  task automatic pop_check();
    exp_t e;
    if (q.size() == 0) begin
      chk("spurious_out", 1, 0);
      return;
    end
    e = q.pop_front();
    lat = cyc - e.cyc;
    chk("abs", 32'(bus.absolute_diff), e.abs_v);
    chk("h_less", 32'(bus.h_less), e.hl);
    chk("win_last", 32'(bus.win_last), e.last);
    if (e.last == 1) begin
      chk("win_sum", 32'(bus.window_sum), e.sum);
      chk("v_major", 32'(bus.win_v_major), e.vmaj);
    end
    seen_abs.push_back(int'(bus.absolute_diff));
    seen_hl.push_back(int'(bus.h_less));
    seen_last.push_back(int'(bus.win_last));
    seen_sum.push_back(int'(bus.window_sum));
    seen_vmaj.push_back(int'(bus.win_v_major));
  endtask
  task automatic seen_clear();
    seen_abs.delete(); seen_hl.delete(); seen_last.delete(); seen_sum.delete(); seen_vmaj.delete();
  endtask
  task automatic step(input logic iv, input int h, input int v, input logic ordy, input logic clr);
    bus.in_valid = iv; bus.green_h = 14'(h); bus.green_v = 14'(v);
    bus.out_ready = ordy; clear = clr;
    #1;
    if (prev_stall) begin
      chk("hold_valid", 32'(bus.out_valid), 1);
      chk("hold_abs", 32'(bus.absolute_diff), snap_abs);
      chk("hold_last", 32'(bus.win_last), snap_last);
      chk("hold_sum", 32'(bus.window_sum), snap_sum);
    end
    if (prev_clr) chk("clr_out_valid", 32'(bus.out_valid), 0);
    prev_stall = bus.out_valid && !ordy && !clr;
    snap_abs = 32'(bus.absolute_diff); snap_last = 32'(bus.win_last); snap_sum = 32'(bus.window_sum);
    prev_clr = clr;
    if (clr) begin
      chk("clr_ready", 32'(bus.in_ready), 1);
      q.delete();
      wcnt = 0; wsum = 0; whl = 0;
    end else begin
      chk("in_ready", 32'(bus.in_ready), 32'(!bus.out_valid || ordy));
      if (bus.out_valid && ordy) pop_check();
      if (iv && bus.in_ready) push(h, v);
    end
    cyc++;
    @(negedge clk);
  endtask
  task automatic drain();
    repeat (12) step(0, 0, 0, 1, 0);
    chk("drain_empty", q.size(), 0);
  endtask
  initial begin
    bus.in_valid = 0; bus.green_h = 0; bus.green_v = 0; bus.out_ready = 1;
    clear = 0; rst_n = 0;
    #2;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_abs", 32'(bus.absolute_diff), 0);
    chk("rst_sum", 32'(bus.window_sum), 0);
    chk("rst_last", 32'(bus.win_last), 0);
    @(negedge clk);
    rst_n = 1;
    #1 chk("rst_ready", 32'(bus.in_ready), 1);
    @(negedge clk);
    // basic latency
    seen_clear();
    step(1, 1000, 400, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    chk("basic_n", seen_abs.size(), 1);
    if (seen_abs.size() > 0) begin
      chk("basic_abs", seen_abs[0], 600);
      chk("basic_hl", seen_hl[0], 0);
      chk("basic_latency", lat, 2);
    end
    // saturation extremes
    seen_clear();
    step(1, 0, 16383, 1, 0);
    step(1, 9000, 500, 1, 0);
    drain();
    chk("sat_n", seen_abs.size(), 2);
    if (seen_abs.size() > 1) begin
      chk("sat_lo_abs", seen_abs[0], 8191);
      chk("sat_lo_hl", seen_hl[0], 1);
      chk("sat_hi_abs", seen_abs[1], 8191);
      chk("sat_hi_hl", seen_hl[1], 0);
    end
    // randomized stream with stalls, bubbles and occasional clears
    for (int i = 0; i < 800; i++) begin
      int h, v;
      h = ($urandom % 8 == 0) ? (($urandom % 2) ? 16383 : 0) : int'($urandom % 16384);
      v = ($urandom % 8 == 0) ? h : int'($urandom % 16384);
      step($urandom % 4 != 0, h, v, $urandom % 4 != 0, $urandom % 60 == 0);
    end
    drain();
    // clear mid-window drops the partial window and the same-cycle sample
    step(1, 50, 10, 1, 0);
    step(1, 60, 10, 1, 0);
    step(1, 70, 10, 1, 0);
    seen_clear();
    step(1, 2000, 1000, 1, 1);
    for (int i = 1; i <= 5; i++) step(1, 100 + i, 100, 1, 0);
    drain();
    chk("clr_n", seen_abs.size(), 5);
    if (seen_abs.size() > 4) begin
      chk("clr_win_last", seen_last[4], 1);
      chk("clr_win_sum", seen_sum[4], 15);
    end
    // asynchronous reset between clock edges
    step(1, 300, 100, 1, 0);
    step(1, 300, 100, 1, 0);
    #3 rst_n = 0;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 0);
    chk("arst_abs", 32'(bus.absolute_diff), 0);
    chk("arst_sum", 32'(bus.window_sum), 0);
    chk("arst_hl", 32'(bus.h_less), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    // window of diffs 10,20,30,40,50 with h_less 1,1,0,1,0, then a sixth sample
    seen_clear();
    step(1, 100, 110, 1, 0);
    step(1, 100, 120, 1, 0);
    step(1, 130, 100, 1, 0);
    step(1, 100, 140, 1, 0);
    step(1, 150, 100, 1, 0);
    step(1, 200, 190, 1, 0);
    drain();
    chk("win_n", seen_abs.size(), 6);
    if (seen_abs.size() > 5) begin
      chk("win4_last", seen_last[3], 0);
      chk("win5_last", seen_last[4], 1);
      chk("win5_sum", seen_sum[4], 150);
      chk("win5_vmaj", seen_vmaj[4], 1);
      chk("win6_last", seen_last[5], 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/abs_diff_pipe.md
Name: abs_diff_pipe

Overview:
- Pipelined, flow-controlled absolute-difference unit for the demosaic gradient path; computes |green_h - green_v| per pixel with a valid/ready handshake.
- Saturates to pixelBitWidth-1 bits instead of truncating.
- Accumulates the magnitudes over a programmable window of accepted samples and reports the window sum plus a direction vote.
- Sits between the green horizontal/vertical interpolators and the edge-direction selector.

Parameters:
- pixelBitWidth, 14, width of the green_h/green_v inputs (unsigned)
- windowLength, 5, samples per accumulation window (2..255)
- sumBitWidth, 16, width of window_sum; must be >= pixelBitWidth-1+ceil(log2(windowLength))

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- clear  input  1  synchronous flush of pipeline and window state
- in_valid  input  1  input sample valid
- in_ready  output  1  block can accept a sample this cycle
- green_h  input  pixelBitWidth  horizontal green estimate, unsigned
- green_v  input  pixelBitWidth  vertical green estimate, unsigned
- out_valid  output  1  output sample valid
- out_ready  input  1  downstream accepts the output
- absolute_diff  output  pixelBitWidth-1  saturated |green_h-green_v|
- h_less  output  1  1 when green_h < green_v for this sample
- win_last  output  1  this output sample closes a window
- window_sum  output  sumBitWidth  sum of absolute_diff over the window; valid only when win_last=1
- win_v_major  output  1  with win_last: 1 when the h_less count is > windowLength/2 (integer division)

Behaviour:
- Reset (rst_n=0, asynchronous): all stage valids=0, out_valid=0, absolute_diff=0, h_less=0, win_last=0, window_sum=0, win_v_major=0, window sample counter=0, running sum=0, h_less count=0. in_ready=1 once reset is released.
- Advance enable: en = !out_valid || out_ready; in_ready = en. The pipeline moves only when en=1. Stalls hold every stage and all outputs stable.
- A transfer occurs when in_valid && in_ready, or out_valid && out_ready.
- Stage 1, on accept: registers the signed difference green_h - green_v at pixelBitWidth+1 bits. s1_valid follows in_valid when en=1.
- Stage 2 (output register), when en=1: computes the magnitude of the stage 1 difference.
  - If the magnitude is >= 2^(pixelBitWidth-1), absolute_diff = 2^(pixelBitWidth-1)-1 (all ones).
  - h_less = sign bit of the stage 1 difference.
  - out_valid = s1_valid.
- Latency: 2 cycles from input accept to out_valid with no stall. Throughput: 1 sample/cycle.
- Window logic updates only when a stage 1 sample moves into stage 2 (s1_valid && en).
  - Counter counts 0..windowLength-1.
  - The sample that takes the counter to windowLength-1 sets win_last=1 with that same sample.
  - window_sum = running sum + this sample's saturated value.
  - win_v_major = (h_less count including this sample) > windowLength/2.
  - Counter, running sum and h_less count then return to 0.
  - Otherwise win_last=0, window_sum holds its last value, and win_v_major holds.
- win_last, window_sum and win_v_major are qualified by out_valid and stay stable during a stall.
- Bubbles (in_valid=0) do not advance the window counter.
- clear=1 (synchronous, priority over in_valid and en):
  - s1_valid=0, out_valid=0, win_last=0; counter, running sum and h_less count go to 0.
  - in_valid in the same cycle is dropped; in_ready=1 during clear.
  - A partial window is discarded.
- Equal inputs: absolute_diff=0, h_less=0.
- Extremes: green_h=0, green_v=2^pixelBitWidth-1 gives a saturated absolute_diff and h_less=1.
- The running sum never overflows when sumBitWidth satisfies the parameter rule. The parameter rule is not checked in RTL.
- rst_n asserted mid-window: everything returns to reset values immediately; in-flight samples are lost.

Test Plan:
- Basic latency: green_h=1000, green_v=400, in_valid for 1 cycle, out_ready=1 -> 2 cycles later out_valid=1, absolute_diff=600, h_less=0.
- Saturation, 14-bit: green_h=0, green_v=16383 -> absolute_diff=8191, h_less=1. green_h=9000, green_v=500 -> absolute_diff=8191, h_less=0.
- Window: windowLength=5, stream differences 10,20,30,40,50 with h_less pattern 1,1,0,1,0 -> on the 5th output win_last=1, window_sum=150, win_v_major=1. The 6th sample starts a new window with win_last=0.
- Backpressure: continuous input, out_ready held 0 for 3 cycles mid-stream -> in_ready=0 while out_valid=1; outputs stable; no sample lost or duplicated; the window boundary stays at sample 5.
- Clear mid-window: after 3 samples assert clear for 1 cycle with in_valid=1 -> that sample is dropped, out_valid=0 next cycle; the next 5 samples form a full window whose sum covers only those 5.
- Async reset mid-stream: drop rst_n asynchronously between clock edges -> all outputs 0 immediately. After release the counter restarts and the first window closes on the 5th new sample.
